// File: rtl/relu_pool_stream_pkg.sv
// rtl/relu_pool_stream_pkg.sv - shared pooling constants and signed-max helper
// Purpose : mode encodings and a width-agnostic signed max used by the pooling lanes.
// Ports   : none (package).
package pool_pkg;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  // Wide enough for any DATA_WIDTH+1 operand; callers sign-extend in and truncate out.
  localparam int MAX_CMP_W = 64;

  function automatic logic signed [MAX_CMP_W-1:0] smax(
    input logic signed [MAX_CMP_W-1:0] a,
    input logic signed [MAX_CMP_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/relu_pool_stream_if.sv
// rtl/relu_pool_stream_if.sv - pixel in / pooled sample out stream bundle
// Purpose : groups the input pixel stream and the pooled output stream.
// Ports   : master drives in_valid/in_sof/in_data and observes out_*;
//           slave (the pooling stage) is the mirror image.
interface relu_pool_stream_if #(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 26
) ();
  logic                         in_valid;
  logic                         in_sof;
  logic [NUM_CH*DATA_WIDTH-1:0] in_data;
  logic                         out_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] out_data;
  logic                         out_eof;

  modport master (
    output in_valid, in_sof, in_data,
    input  out_valid, out_data, out_eof
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output out_valid, out_data, out_eof
  );
endinterface

// File: rtl/relu_pool_stream_line_buffer.sv
// rtl/relu_pool_stream_line_buffer.sv - one-row store of horizontal pair values
// Purpose : holds the even-row pair values until the odd row consumes them.
// Ports   : clk; we/addr/wdata synchronous write; rdata combinational read of addr.
module pool_line_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 54,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset: every entry is rewritten on the even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Combinational read keeps the pooled result one cycle behind its last pixel.
  assign rdata = mem[addr];

endmodule

// File: rtl/relu_pool_stream.sv
// rtl/relu_pool_stream.sv - multi-channel ReLU + 2x2/stride-2 max/avg pooling stage
// Purpose : counts pixels, latches per-frame config, applies ReLU, pools 2x2 windows.
// Ports   : clk, rst (sync, active-high); cfg_mode (0 max / 1 avg), cfg_relu sampled at (0,0);
//           bus (slave) carries the pixel stream in and pooled samples out;
//           frame_err pulses one cycle after an in_sof seen mid-frame.
module relu_pool_stream
  import pool_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 26,
  parameter int IMG_W      = 128,
  parameter int IMG_H      = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_mode,
  input  logic               cfg_relu,
  relu_pool_stream_if.slave  bus,
  output logic               frame_err
);

  localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB_DEPTH = IMG_W / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam int VW       = NUM_CH * DATA_WIDTH;
  localparam int PW       = NUM_CH * (DATA_WIDTH + 1);

  logic [CW-1:0] col_q, col_d, eff_col;
  logic [RW-1:0] row_q, row_d, eff_row;
  logic          mode_q, mode_d, relu_q, relu_d, mode_cur, relu_cur;
  logic [VW-1:0] hold_q, hold_d, out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d, out_eof_q, out_eof_d;
  logic          frame_err_q, frame_err_d;
  logic          restart, at_origin, first_pix, fire, lb_we;
  logic [LB_AW-1:0] lb_addr;

  wire [VW-1:0] relu_px;
  wire [VW-1:0] lane_res;
  wire [PW-1:0] lb_wdata;
  wire [PW-1:0] lb_rdata;

  // Position decode: an accepted in_sof forces this pixel to (0,0) regardless of the counters.
  always_comb begin
    at_origin = (row_q == '0) && (col_q == '0);
    restart   = bus.in_valid && bus.in_sof;
    eff_col   = restart ? '0 : col_q;
    eff_row   = restart ? '0 : row_q;
    first_pix = bus.in_valid && (eff_col == '0) && (eff_row == '0);
    // The (0,0) pixel already uses the freshly sampled config.
    mode_cur  = first_pix ? cfg_mode : mode_q;
    relu_cur  = first_pix ? cfg_relu : relu_q;
    fire      = bus.in_valid && eff_col[0] && eff_row[0];
    lb_we     = bus.in_valid && eff_col[0] && !eff_row[0];
    lb_addr   = LB_AW'(eff_col >> 1);
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] x, px, hold_v;
    logic signed [DATA_WIDTH:0]   pair, lb_val;
    logic signed [DATA_WIDTH+1:0] avg_sum;

    assign x      = bus.in_data[c*DATA_WIDTH +: DATA_WIDTH];
    assign px     = (relu_cur && x[DATA_WIDTH-1]) ? '0 : x;
    assign hold_v = hold_q[c*DATA_WIDTH +: DATA_WIDTH];
    assign lb_val = lb_rdata[c*(DATA_WIDTH+1) +: DATA_WIDTH+1];

    assign pair = (mode_cur == POOL_AVG)
                ? ((DATA_WIDTH+1)'(hold_v) + (DATA_WIDTH+1)'(px))
                : (DATA_WIDTH+1)'(smax(MAX_CMP_W'(hold_v), MAX_CMP_W'(px)));

    assign avg_sum = (DATA_WIDTH+2)'(pair) + (DATA_WIDTH+2)'(lb_val);

    assign relu_px[c*DATA_WIDTH +: DATA_WIDTH]         = px;
    assign lb_wdata[c*(DATA_WIDTH+1) +: DATA_WIDTH+1]  = pair;
    // Arithmetic shift floors the 4-sample mean; the mean of DATA_WIDTH values always fits.
    assign lane_res[c*DATA_WIDTH +: DATA_WIDTH] = (mode_cur == POOL_AVG)
                ? DATA_WIDTH'(avg_sum >>> 2)
                : DATA_WIDTH'(smax(MAX_CMP_W'(pair), MAX_CMP_W'(lb_val)));
  end

  pool_line_buffer #(
    .DEPTH (LB_DEPTH),
    .WIDTH (PW)
  ) u_line_buffer (
    .clk   (clk),
    .we    (lb_we),
    .addr  (lb_addr),
    .wdata (lb_wdata),
    .rdata (lb_rdata)
  );

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    mode_d      = mode_q;
    relu_d      = relu_q;
    hold_d      = hold_q;
    if (first_pix) begin
      mode_d = cfg_mode;
      relu_d = cfg_relu;
    end
    if (bus.in_valid) begin
      if (eff_col == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (eff_row == RW'(IMG_H - 1)) ? '0 : eff_row + 1'b1;
      end else begin
        col_d = eff_col + 1'b1;
        row_d = eff_row;
      end
      if (!eff_col[0]) hold_d = relu_px;
    end
    out_valid_d = fire;
    out_eof_d   = fire && (eff_row == RW'(IMG_H - 1)) && (eff_col == CW'(IMG_W - 1));
    frame_err_d = restart && !at_origin;
    out_data_d  = fire ? lane_res : out_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= POOL_MAX;
      relu_q      <= 1'b0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
      frame_err_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      mode_q      <= mode_d;
      relu_q      <= relu_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_eof_q   <= out_eof_d;
      frame_err_q <= frame_err_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_eof   = out_eof_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_relu_pool_stream.sv
// tb/tb_relu_pool_stream.sv - self-checking bench for relu_pool_stream
module tb_relu_pool_stream;

  localparam int W   = 4;
  localparam int H   = 4;
  localparam int N   = W * H;
  localparam int DW  = 26;
  localparam int NCH = 2;
  localparam int NO  = (W / 2) * (H / 2);

  logic clk = 1'b0;
  logic rst;
  logic cfg_mode;
  logic cfg_relu;
  logic frame_err;

  always #5 clk = ~clk;

  relu_pool_stream_if #(.NUM_CH(NCH), .DATA_WIDTH(DW)) bus ();

  relu_pool_stream #(
    .NUM_CH     (NCH),
    .DATA_WIDTH (DW),
    .IMG_W      (W),
    .IMG_H      (H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_mode  (cfg_mode),
    .cfg_relu  (cfg_relu),
    .bus       (bus),
    .frame_err (frame_err)
  );

  int errors = 0;
  int checks = 0;

  longint fr0 [N];
  longint fr1 [N];
  longint ex0 [NO];
  longint ex1 [NO];
  int     pos;
  logic [2*DW-1:0] last_out;

  function automatic logic [2*DW-1:0] pack(input longint a, input longint b);
    logic [63:0] ua;
    logic [63:0] ub;
    ua = a;
    ub = b;
    return {ub[DW-1:0], ua[DW-1:0]};
  endfunction

  function automatic longint rnd26();
    return longint'($urandom_range(0, 67108863)) - 64'sd33554432;
  endfunction

  // Pool one 2x2 window straight from the arithmetic definition.
  function automatic longint ref_pool(input longint a, input longint b, input longint c,
                                      input longint d, input bit mode, input bit relu);
    longint v [4];
    longint m;
    longint s;
    longint q;
    v = '{a, b, c, d};
    for (int k = 0; k < 4; k++) if (relu && v[k] < 0) v[k] = 0;
    if (!mode) begin
      m = v[0];
      for (int k = 1; k < 4; k++) if (v[k] > m) m = v[k];
      return m;
    end
    s = v[0] + v[1] + v[2] + v[3];
    q = s / 4;
    if ((s % 4 != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  function automatic void model_frame(input bit mode, input bit relu);
    int b;
    for (int oy = 0; oy < H / 2; oy++) begin
      for (int ox = 0; ox < W / 2; ox++) begin
        b = (2 * oy) * W + 2 * ox;
        ex0[oy*(W/2)+ox] = ref_pool(fr0[b], fr0[b+1], fr0[b+W], fr0[b+W+1], mode, relu);
        ex1[oy*(W/2)+ox] = ref_pool(fr1[b], fr1[b+1], fr1[b+W], fr1[b+W+1], mode, relu);
      end
    end
  endfunction

  // Sends the first npix pixels of fr0/fr1, optionally with random idle gaps, and checks
  // every cycle's outputs against the model. Config inputs are randomised off (0,0).
  task automatic run_frame(input int npix, input bit use_sof, input bit mode, input bit relu,
                           input int maxgap, output int n_out, output int n_err);
    int  gap;
    int  r;
    int  c;
    bit  ev;
    bit  eeof;
    bit  eerr;
    n_out = 0;
    n_err = 0;
    model_frame(mode, relu);
    for (int i = 0; i < npix; i++) begin
      gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'($urandom);
        bus.in_data  = pack(rnd26(), rnd26());
        cfg_mode     = 1'($urandom);
        cfg_relu     = 1'($urandom);
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_eof !== 1'b0 || frame_err !== 1'b0 ||
            bus.out_data !== last_out) begin
          errors++;
          $display("FAIL idle_quiet: valid=%b eof=%b err=%b data=%h, required 0 0 0 data=%h",
                   bus.out_valid, bus.out_eof, frame_err, bus.out_data, last_out);
        end
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_sof   = (i == 0) && use_sof;
      bus.in_data  = pack(fr0[i], fr1[i]);
      cfg_mode     = (i == 0) ? mode : 1'($urandom);
      cfg_relu     = (i == 0) ? relu : 1'($urandom);
      eerr = (i == 0) && use_sof && (pos != 0);
      r    = i / W;
      c    = i % W;
      ev   = (r % 2 == 1) && (c % 2 == 1);
      eeof = ev && (i == N - 1);
      if (ev) last_out = pack(ex0[(r/2)*(W/2)+c/2], ex1[(r/2)*(W/2)+c/2]);
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== ev) begin
        errors++;
        $display("FAIL out_valid px%0d: got %b, required %b", i, bus.out_valid, ev);
      end
      checks++;
      if (bus.out_data !== last_out) begin
        errors++;
        $display("FAIL out_data px%0d: got %h, required %h", i, bus.out_data, last_out);
      end
      checks++;
      if (bus.out_eof !== eeof) begin
        errors++;
        $display("FAIL out_eof px%0d: got %b, required %b", i, bus.out_eof, eeof);
      end
      checks++;
      if (frame_err !== eerr) begin
        errors++;
        $display("FAIL frame_err px%0d: got %b, required %b", i, frame_err, eerr);
      end
      if (bus.out_valid === 1'b1) n_out++;
      if (frame_err === 1'b1) n_err++;
      pos = (i + 1) % N;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < N; i++) begin
      fr0[i] = i;
      fr1[i] = -i;
    end
  endtask

  task automatic load_const(input longint v);
    for (int i = 0; i < N; i++) begin
      fr0[i] = v;
      fr1[i] = -v;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_sof   = 1'($urandom);
      bus.in_data  = pack(rnd26(), rnd26());
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_eof !== 1'b0 || frame_err !== 1'b0 ||
        bus.out_data !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b eof=%b err=%b data=%h, required all zero",
               bus.out_valid, bus.out_eof, frame_err, bus.out_data);
    end
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    pos          = 0;
    last_out     = '0;
  endtask

  task automatic test_max_ramp();
    int no, ne;
    load_ramp();
    run_frame(N, 1'b0, 1'b0, 1'b0, 0, no, ne);
    checks++;
    if (no !== NO) begin
      errors++;
      $display("FAIL max_ramp_count: got %0d outputs, required %0d", no, NO);
    end
    checks++;
    if (last_out !== pack(15, -10) || bus.out_data !== pack(15, -10)) begin
      errors++;
      $display("FAIL max_ramp_last: got %h, required %h", bus.out_data, pack(15, -10));
    end
  endtask

  task automatic test_avg_ramp();
    int no, ne;
    load_ramp();
    run_frame(N, 1'b1, 1'b1, 1'b0, 0, no, ne);
    checks++;
    if (bus.out_data !== pack(12, -13)) begin
      errors++;
      $display("FAIL avg_ramp_last: got %h, required %h", bus.out_data, pack(12, -13));
    end
  endtask

  task automatic test_relu_edges();
    int no, ne;
    load_const(-3);
    for (int k = 0; k < N; k++) fr1[k] = -3;
    run_frame(N, 1'b1, 1'b0, 1'b1, 0, no, ne);
    checks++;
    if (bus.out_data !== pack(0, 0)) begin
      errors++;
      $display("FAIL relu_clamp: got %h, required %h", bus.out_data, pack(0, 0));
    end
    run_frame(N, 1'b1, 1'b0, 1'b0, 0, no, ne);
    checks++;
    if (bus.out_data !== pack(-3, -3)) begin
      errors++;
      $display("FAIL relu_off_max: got %h, required %h", bus.out_data, pack(-3, -3));
    end
    load_const(-1);
    fr0[N-1] = -2;
    fr1[N-1] = 2;
    run_frame(N, 1'b1, 1'b1, 1'b0, 0, no, ne);
    checks++;
    if (bus.out_data !== pack(-2, 1)) begin
      errors++;
      $display("FAIL avg_floor: got %h, required %h", bus.out_data, pack(-2, 1));
    end
    load_const(33554431);
    run_frame(N, 1'b1, 1'b1, 1'b0, 0, no, ne);
    checks++;
    if (bus.out_data !== pack(33554431, -33554431)) begin
      errors++;
      $display("FAIL avg_full_scale: got %h, required %h", bus.out_data,
               pack(33554431, -33554431));
    end
  endtask

  task automatic test_gaps();
    int no, ne;
    load_ramp();
    run_frame(N, 1'b1, 1'b0, 1'b0, 3, no, ne);
    checks++;
    if (no !== NO || bus.out_data !== pack(15, -10)) begin
      errors++;
      $display("FAIL gapped_ramp: got %0d outputs last %h, required %0d last %h",
               no, bus.out_data, NO, pack(15, -10));
    end
  endtask

  task automatic test_sof_resync();
    int no, ne;
    load_ramp();
    run_frame(5, 1'b1, 1'b0, 1'b0, 0, no, ne);
    checks++;
    if (no !== 0) begin
      errors++;
      $display("FAIL aborted_outputs: got %0d, required 0", no);
    end
    run_frame(N, 1'b1, 1'b0, 1'b0, 0, no, ne);
    checks++;
    if (ne !== 1 || no !== NO || bus.out_data !== pack(15, -10)) begin
      errors++;
      $display("FAIL sof_resync: got err=%0d outputs=%0d last=%h, required 1 %0d %h",
               ne, no, bus.out_data, NO, pack(15, -10));
    end
  endtask

  task automatic test_rst_mid_frame();
    int no, ne;
    load_ramp();
    run_frame(10, 1'b1, 1'b1, 1'b0, 0, no, ne);
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sof   = 1'b0;
    bus.in_data  = pack(rnd26(), rnd26());
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_eof !== 1'b0 || frame_err !== 1'b0 ||
        bus.out_data !== '0) begin
      errors++;
      $display("FAIL rst_mid_frame: valid=%b eof=%b err=%b data=%h, required all zero",
               bus.out_valid, bus.out_eof, frame_err, bus.out_data);
    end
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    pos          = 0;
    last_out     = '0;
    run_frame(N, 1'b1, 1'b0, 1'b0, 0, no, ne);
    checks++;
    if (ne !== 0 || bus.out_data !== pack(15, -10)) begin
      errors++;
      $display("FAIL post_rst_frame: got err=%0d last=%h, required 0 %h",
               ne, bus.out_data, pack(15, -10));
    end
  endtask

  task automatic test_back_to_back();
    int no, ne;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < N; i++) begin
        fr0[i] = rnd26();
        fr1[i] = rnd26();
      end
      run_frame(N, 1'($urandom), 1'($urandom), 1'($urandom), (f % 2) * 2, no, ne);
      checks++;
      if (no !== NO || ne !== 0) begin
        errors++;
        $display("FAIL random_frame%0d: got outputs=%0d err=%0d, required %0d 0",
                 f, no, ne, NO);
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    cfg_mode     = 1'b0;
    cfg_relu     = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;
    pos          = 0;
    last_out     = '0;
    test_reset();
    test_max_ramp();
    test_avg_ramp();
    test_relu_edges();
    test_gaps();
    test_sof_resync();
    test_rst_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
